// File: rtl/pw_lock_ctrl_pkg.sv
// Shared types and default sizing for the password lock controller.
package pw_lock_pkg;

  localparam int DEF_DIGITS   = 4;
  localparam int DEF_DIGIT_W  = 4;
  localparam int DEF_MAX_FAIL = 3;

  localparam int PW_W   = DEF_DIGITS * DEF_DIGIT_W;
  localparam int CNT_W  = $clog2(DEF_DIGITS + 1);
  localparam int FAIL_W = $clog2(DEF_MAX_FAIL + 1);

  localparam logic [PW_W-1:0] DEF_PW = 16'h1234;

  typedef enum logic [1:0] {
    ENTRY,
    OPEN,
    LOCKOUT
  } state_e;

  // One keypad event per cycle; clear beats confirm beats a digit.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_CLEAR,
    EV_CONFIRM,
    EV_KEY
  } event_e;

  function automatic event_e decode_event(input logic star, input logic sharp,
                                          input logic key_valid);
    if (star)      return EV_CLEAR;
    if (sharp)     return EV_CONFIRM;
    if (key_valid) return EV_KEY;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/pw_lock_ctrl_if.sv
// Keypad-side and indicator-side signals of the lock controller.
interface pw_lock_ctrl_if import pw_lock_pkg::*; #(
  parameter int DIGITS   = DEF_DIGITS,
  parameter int DIGIT_W  = DEF_DIGIT_W,
  parameter int MAX_FAIL = DEF_MAX_FAIL
);
  localparam int W_PW   = DIGITS * DIGIT_W;
  localparam int W_CNT  = $clog2(DIGITS + 1);
  localparam int W_FAIL = $clog2(MAX_FAIL + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key;
  logic               star;
  logic               sharp;
  logic               prog_en;

  logic               pw_ok;
  logic               pw_fail;
  logic               prog_done;
  logic               locked;
  logic [W_FAIL-1:0]  fail_cnt;
  logic [W_CNT-1:0]   entry_cnt;
  logic [W_PW-1:0]    entry;

  modport master (
    output key_valid, key, star, sharp, prog_en,
    input  pw_ok, pw_fail, prog_done, locked, fail_cnt, entry_cnt, entry
  );

  modport slave (
    input  key_valid, key, star, sharp, prog_en,
    output pw_ok, pw_fail, prog_done, locked, fail_cnt, entry_cnt, entry
  );

endinterface

// File: rtl/pw_lock_ctrl_entry_buf.sv
// Keypad entry shift buffer: newest digit lands in the low digit slot.
module pw_entry_buf import pw_lock_pkg::*; #(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [DIGIT_W-1:0]           digit_i,
  output logic [DIGITS*DIGIT_W-1:0]    entry_o,
  output logic [$clog2(DIGITS+1)-1:0]  cnt_o,
  output logic                         full_o
);
  localparam int W_PW  = DIGITS * DIGIT_W;
  localparam int W_CNT = $clog2(DIGITS + 1);

  logic [W_PW-1:0]  entry_q;
  logic [W_CNT-1:0] cnt_q;

  assign full_o  = (cnt_q == W_CNT'(DIGITS));
  assign entry_o = entry_q;
  assign cnt_o   = cnt_q;

  // Clear wins over push; a push into a full buffer is dropped so nothing is overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      entry_q <= '0;
      cnt_q   <= '0;
    end else if (push_i && !full_o) begin
      entry_q <= (entry_q << DIGIT_W) | W_PW'(digit_i);
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pw_lock_ctrl.sv
// Password lock controller: entry compare, reprogramming and timed lockout.
module pw_lock_ctrl import pw_lock_pkg::*; #(
  parameter int                        DIGITS      = DEF_DIGITS,
  parameter int                        DIGIT_W     = DEF_DIGIT_W,
  parameter int                        MAX_DIGIT   = 9,
  parameter int                        MAX_FAIL    = DEF_MAX_FAIL,
  parameter int                        LOCK_CYCLES = 16,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PW  = DEF_PW
) (
  input  logic           clk,
  input  logic           rst,
  pw_lock_ctrl_if.slave  bus
);
  localparam int W_PW   = DIGITS * DIGIT_W;
  localparam int W_CNT  = $clog2(DIGITS + 1);
  localparam int W_FAIL = $clog2(MAX_FAIL + 1);
  localparam int W_TMR  = $clog2(LOCK_CYCLES + 1);

  localparam logic [W_FAIL-1:0]  FAIL_LIMIT = W_FAIL'(MAX_FAIL);
  localparam logic [W_TMR-1:0]   LOCK_LOAD  = W_TMR'(LOCK_CYCLES);
  localparam logic [DIGIT_W-1:0] KEY_MAX    = DIGIT_W'(MAX_DIGIT);

  state_e            state_q;
  logic [W_PW-1:0]   stored_q;
  logic [W_FAIL-1:0] fail_q;
  logic [W_FAIL-1:0] fail_d;
  logic [W_TMR-1:0]  timer_q;
  logic              pw_ok_q;
  logic              pw_fail_q;
  logic              prog_done_q;
  logic              locked_q;

  event_e            ev;
  logic              buf_clear;
  logic              buf_push;
  logic              buf_full;
  logic              match;
  logic [W_PW-1:0]   entry;
  logic [W_CNT-1:0]  entry_cnt;

  pw_entry_buf #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W)
  ) u_entry_buf (
    .clk     (clk),
    .rst     (rst),
    .clear_i (buf_clear),
    .push_i  (buf_push),
    .digit_i (bus.key),
    .entry_o (entry),
    .cnt_o   (entry_cnt),
    .full_o  (buf_full)
  );

  // Decode the keypad event, steer the buffer and form the compare and next fail count.
  always_comb begin
    ev        = decode_event(bus.star, bus.sharp, bus.key_valid);
    buf_clear = 1'b0;
    buf_push  = 1'b0;
    if (state_q != LOCKOUT) begin
      buf_clear = (ev == EV_CLEAR) || (ev == EV_CONFIRM);
      buf_push  = (ev == EV_KEY) && (bus.key <= KEY_MAX);
    end
    match  = buf_full && (entry == stored_q);
    fail_d = (fail_q >= FAIL_LIMIT) ? FAIL_LIMIT : fail_q + 1'b1;
  end

  // Lock FSM with its stored password, failure counter, lockout timer and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ENTRY;
      stored_q    <= DEFAULT_PW;
      fail_q      <= '0;
      timer_q     <= '0;
      pw_ok_q     <= 1'b0;
      pw_fail_q   <= 1'b0;
      prog_done_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      pw_fail_q   <= 1'b0;
      prog_done_q <= 1'b0;
      case (state_q)
        ENTRY: begin
          if (ev == EV_CONFIRM) begin
            if (match) begin
              state_q <= OPEN;
              fail_q  <= '0;
              pw_ok_q <= 1'b1;
            end else begin
              pw_fail_q <= 1'b1;
              fail_q    <= fail_d;
              if (fail_d == FAIL_LIMIT) begin
                state_q  <= LOCKOUT;
                timer_q  <= LOCK_LOAD;
                locked_q <= 1'b1;
              end
            end
          end
        end
        OPEN: begin
          if (ev == EV_CONFIRM) begin
            if (bus.prog_en) begin
              if (buf_full) begin
                stored_q    <= entry;
                prog_done_q <= 1'b1;
              end
            end else begin
              state_q <= ENTRY;
              pw_ok_q <= 1'b0;
            end
          end
        end
        LOCKOUT: begin
          if (timer_q == W_TMR'(1)) begin
            state_q  <= ENTRY;
            timer_q  <= '0;
            fail_q   <= '0;
            locked_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          state_q  <= ENTRY;
          pw_ok_q  <= 1'b0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pw_ok     = pw_ok_q;
  assign bus.pw_fail   = pw_fail_q;
  assign bus.prog_done = prog_done_q;
  assign bus.locked    = locked_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.entry_cnt = entry_cnt;
  assign bus.entry     = entry;

endmodule

// File: tb/tb_pw_lock_ctrl.sv
// Bench for pw_lock_ctrl: directed scenarios plus random keypad traffic against a digit-list model.
module tb_pw_lock_ctrl;
  localparam int DIGITS      = 4;
  localparam int DIGIT_W     = 4;
  localparam int MAX_DIGIT   = 9;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 16;
  localparam logic [15:0] DEFAULT_PW = 16'h1234;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pw_lock_ctrl_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAIL(MAX_FAIL)) bus ();

  pw_lock_ctrl #(
    .DIGITS      (DIGITS),
    .DIGIT_W     (DIGIT_W),
    .MAX_DIGIT   (MAX_DIGIT),
    .MAX_FAIL    (MAX_FAIL),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DEFAULT_PW  (DEFAULT_PW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  nChecks = 0;
  int  nFails  = 0;
  bit  modelEn = 1'b0;
  bit  checkEn = 1'b0;
  bit  progEnReq = 1'b0;

  // Reference model: typed digits as a list, lock as a countdown of remaining cycles.
  bit     mOpen;
  int     mLockLeft;
  int     mFails;
  int     mDigits[$];
  longint mStored;
  bit     expPwFail;
  bit     expProgDone;

  function automatic longint entryValue();
    longint v = 0;
    foreach (mDigits[i]) v = v * (64'd1 << DIGIT_W) + longint'(mDigits[i]);
    return v;
  endfunction

  task automatic modelReset();
    mOpen       = 1'b0;
    mLockLeft   = 0;
    mFails      = 0;
    mDigits.delete();
    mStored     = longint'(DEFAULT_PW);
    expPwFail   = 1'b0;
    expProgDone = 1'b0;
  endtask

  task automatic modelStep(input bit kv, input int key, input bit st, input bit sh, input bit pe);
    expPwFail   = 1'b0;
    expProgDone = 1'b0;
    if (mLockLeft > 0) begin
      mLockLeft--;
      if (mLockLeft == 0) mFails = 0;
    end else if (st) begin
      mDigits.delete();
    end else if (sh) begin
      if (!mOpen) begin
        if (mDigits.size() == DIGITS && entryValue() == mStored) begin
          mOpen  = 1'b1;
          mFails = 0;
        end else begin
          expPwFail = 1'b1;
          mFails    = (mFails + 1 > MAX_FAIL) ? MAX_FAIL : mFails + 1;
          if (mFails == MAX_FAIL) mLockLeft = LOCK_CYCLES;
        end
      end else if (pe) begin
        if (mDigits.size() == DIGITS) begin
          mStored     = entryValue();
          expProgDone = 1'b1;
        end
      end else begin
        mOpen = 1'b0;
      end
      mDigits.delete();
    end else if (kv && key <= MAX_DIGIT && mDigits.size() < DIGITS) begin
      mDigits.push_back(key);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (modelEn) modelStep(bus.key_valid, int'(bus.key), bus.star, bus.sharp, bus.prog_en);
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmp_pw_ok",     64'(bus.pw_ok),     64'(mOpen));
      checkOutput("cmp_locked",    64'(bus.locked),    64'(mLockLeft > 0));
      checkOutput("cmp_pw_fail",   64'(bus.pw_fail),   64'(expPwFail));
      checkOutput("cmp_prog_done", 64'(bus.prog_done), 64'(expProgDone));
      checkOutput("cmp_fail_cnt",  64'(bus.fail_cnt),  64'(mFails));
      checkOutput("cmp_entry_cnt", 64'(bus.entry_cnt), 64'(mDigits.size()));
      checkOutput("cmp_entry",     64'(bus.entry),     64'(entryValue()));
    end
  end

  // One cycle of keypad inputs, returning just after the sampling edge.
  task automatic applyStimulus(input bit kv, input int key, input bit st, input bit sh);
    @(negedge clk);
    bus.key_valid = kv;
    bus.key       = DIGIT_W'(key);
    bus.star      = st;
    bus.sharp     = sh;
    bus.prog_en   = progEnReq;
    @(posedge clk);
    #1;
  endtask

  task automatic pressKey(input int d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pressSharp();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic typeCode(input logic [15:0] code);
    for (int i = DIGITS - 1; i >= 0; i--) pressKey(int'((code >> (i * DIGIT_W)) & 16'hF));
  endtask

  int r;

  initial begin
    rst           = 1'b0;
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.star      = 1'b0;
    bus.sharp     = 1'b0;
    bus.prog_en   = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pw_ok",     64'(bus.pw_ok),     64'd0);
    checkOutput("reset_locked",    64'(bus.locked),    64'd0);
    checkOutput("reset_pw_fail",   64'(bus.pw_fail),   64'd0);
    checkOutput("reset_entry",     64'(bus.entry),     64'd0);
    checkOutput("reset_entry_cnt", 64'(bus.entry_cnt), 64'd0);
    checkOutput("reset_fail_cnt",  64'(bus.fail_cnt),  64'd0);
    @(negedge clk);
    rst     = 1'b1;
    modelEn = 1'b1;
    checkEn = 1'b1;

    // Default password opens one cycle after confirm.
    typeCode(16'h1234);
    pressSharp();
    checkOutput("open_pw_ok",    64'(bus.pw_ok),    64'd1);
    checkOutput("open_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    checkOutput("open_entry",    64'(bus.entry),    64'd0);
    progEnReq = 1'b0;
    pressSharp();
    checkOutput("close_pw_ok", 64'(bus.pw_ok), 64'd0);

    // Three wrong codes lock the keypad for exactly LOCK_CYCLES cycles.
    for (int n = 1; n <= MAX_FAIL; n++) begin
      typeCode(16'h1235);
      pressSharp();
      checkOutput("wrong_pw_fail",  64'(bus.pw_fail),  64'd1);
      checkOutput("wrong_fail_cnt", 64'(bus.fail_cnt), 64'(n));
      checkOutput("wrong_locked",   64'(bus.locked),   64'(n == MAX_FAIL));
    end
    for (int c = 1; c < LOCK_CYCLES; c++) applyStimulus(1'b1, c % 10, c == 5, c == 9);
    checkOutput("lock_hold_locked", 64'(bus.locked), 64'd1);
    checkOutput("lock_hold_entry",  64'(bus.entry),  64'd0);
    idleCycle();
    checkOutput("lock_end_locked",   64'(bus.locked),   64'd0);
    checkOutput("lock_end_fail_cnt", 64'(bus.fail_cnt), 64'd0);

    // Reprogram to 9876, then only the new code opens.
    typeCode(16'h1234);
    pressSharp();
    progEnReq = 1'b1;
    typeCode(16'h9876);
    pressSharp();
    checkOutput("prog_done_pulse", 64'(bus.prog_done), 64'd1);
    checkOutput("prog_pw_ok",      64'(bus.pw_ok),     64'd1);
    idleCycle();
    checkOutput("prog_done_drop",  64'(bus.prog_done), 64'd0);
    progEnReq = 1'b0;
    pressSharp();
    checkOutput("prog_close_pw_ok", 64'(bus.pw_ok), 64'd0);
    typeCode(16'h9876);
    pressSharp();
    checkOutput("new_code_pw_ok", 64'(bus.pw_ok), 64'd1);
    pressSharp();
    typeCode(16'h1234);
    pressSharp();
    checkOutput("old_code_pw_fail", 64'(bus.pw_fail), 64'd1);

    // Full buffer drops extra keys; codes above MAX_DIGIT are ignored.
    typeCode(16'h1234);
    pressKey(5);
    checkOutput("full_entry",     64'(bus.entry),     64'h1234);
    checkOutput("full_entry_cnt", 64'(bus.entry_cnt), 64'd4);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    pressKey(4'hA);
    pressKey(3);
    pressKey(4'hF);
    checkOutput("badkey_entry",     64'(bus.entry),     64'h3);
    checkOutput("badkey_entry_cnt", 64'(bus.entry_cnt), 64'd1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Star beats sharp; a short entry is a failure.
    pressKey(1);
    pressKey(2);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    checkOutput("star_sharp_entry",   64'(bus.entry),   64'd0);
    checkOutput("star_sharp_pw_fail", 64'(bus.pw_fail), 64'd0);
    pressKey(1);
    pressKey(2);
    pressKey(3);
    applyStimulus(1'b1, 4, 1'b0, 1'b1);
    checkOutput("short_pw_fail",  64'(bus.pw_fail),  64'd1);
    checkOutput("short_fail_cnt", 64'(bus.fail_cnt), 64'd2);

    // Reset while open after reprogramming restores the default password.
    typeCode(16'h9876);
    pressSharp();
    progEnReq = 1'b1;
    typeCode(16'h5555);
    pressSharp();
    checkOutput("reprog2_done", 64'(bus.prog_done), 64'd1);
    checkEn = 1'b0;
    modelEn = 1'b0;
    rst     = 1'b0;
    #1;
    checkOutput("async_rst_pw_ok",    64'(bus.pw_ok),    64'd0);
    checkOutput("async_rst_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    modelReset();
    progEnReq = 1'b0;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.star      = 1'b0;
    bus.sharp     = 1'b0;
    bus.prog_en   = 1'b0;
    rst     = 1'b1;
    modelEn = 1'b1;
    checkEn = 1'b1;
    typeCode(16'h1234);
    pressSharp();
    checkOutput("default_back_pw_ok", 64'(bus.pw_ok), 64'd1);
    pressSharp();

    // Random keypad traffic, with the stored code typed now and then so OPEN is reached.
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 19) == 0) progEnReq = ~progEnReq;
      if (r < 3)       applyStimulus(1'b0, 0, 1'b1, 1'($urandom_range(0, 1)));
      else if (r < 9)  applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'b0, 1'b1);
      else if (r < 13) begin
        typeCode(16'(mStored));
        pressSharp();
      end
      else if (r < 60) applyStimulus(1'b1, int'($urandom_range(0, 11)), 1'b0, 1'b0);
      else             applyStimulus(1'b0, int'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
    idleCycle();
    idleCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
